// File: rtl/cache_req_agent_pkg.sv
// Shared coherence definitions for the cache request agent:
// message type encodings, datapath widths and a PUT_* classifier.
package cache_req_agent_pkg;

    localparam int WIDTH      = 32;
    localparam int BLOCK_SIZE = 64;
    localparam int CPU_WIDTH  = 2;

    localparam logic [3:0] NONE         = 4'd0;
    localparam logic [3:0] GET_S        = 4'd1;
    localparam logic [3:0] GET_M        = 4'd2;
    localparam logic [3:0] PUT_S        = 4'd3;
    localparam logic [3:0] PUT_E        = 4'd4;
    localparam logic [3:0] PUT_M        = 4'd5;
    localparam logic [3:0] DATA         = 4'd6;
    localparam logic [3:0] FORWARD_DATA = 4'd7;

    function automatic logic is_put(input logic [3:0] t);
        return (t == PUT_S) || (t == PUT_E) || (t == PUT_M);
    endfunction

endpackage

// File: rtl/cache_req_agent_inv_ack_counter.sv
// Invalidation-ack accounting: saturating count of peer acks plus the
// "enough acks" compare.
// Ports: clk_i, rst_ni (sync, active low), clr_i (hold at zero),
// inc_i (one ack this cycle), target_i (acks required),
// reached_o (count including this cycle's ack >= target).
module inv_ack_counter
    import cache_req_agent_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 inc_i,
    input  logic [CPU_WIDTH-1:0] target_i,
    output logic                 reached_o
);

    logic [CPU_WIDTH:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + (CPU_WIDTH+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Compare against the post-update count so an ack landing in the
    // same cycle as the data (or as the final WAIT_ACK cycle) counts.
    assign reached_o = cnt_d >= {1'b0, target_i};

endmodule

// File: rtl/cache_req_agent.sv
// Cache request agent: issues one core request to the crossbar, collects
// the response and invalidation acks, and relays directory invalidations.
// Ports: core_req_* / core_done* (core side), tx_* / rx_* (crossbar),
// last_ack_i (peer acks), inv_* (directory invalidations), timeout_err.
// Optional watchdog enabled by defining REQ_TIMEOUT_EN.
module cache_req_agent
    import cache_req_agent_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  core_req_valid,
    input  logic [3:0]            core_req_type,
    input  logic [WIDTH-1:0]      core_req_addr,
    input  logic [BLOCK_SIZE-1:0] core_req_data,
    output logic                  core_req_ready,
    output logic                  core_done,
    output logic [BLOCK_SIZE-1:0] core_done_data,
    output logic                  core_done_excl,
    output logic                  core_inv_en,
    output logic [WIDTH-1:0]      core_inv_addr,
    output logic                  tx_en,
    output logic [3:0]            tx_type,
    output logic [BLOCK_SIZE-1:0] tx_data,
    output logic [WIDTH-1:0]      tx_addr,
    input  logic                  tx_grant_i,
    input  logic                  rx_en,
    input  logic [3:0]            rx_type,
    input  logic [BLOCK_SIZE-1:0] rx_data,
    input  logic [WIDTH-1:0]      rx_addr,
    input  logic                  rx_exclusive,
    input  logic [CPU_WIDTH-1:0]  rx_ack_num,
    input  logic                  rx_put_ack,
    input  logic [CPU_WIDTH-1:0]  last_ack_i,
    input  logic                  inv_en_i,
    input  logic [WIDTH-1:0]      inv_addr_i,
    output logic                  inv_ack_o,
    output logic                  timeout_err
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_RESP = 3'd2;
    localparam logic [2:0] S_WAIT_ACK  = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    if (TIMEOUT_CYCLES < 1) begin : g_cfg_chk
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [2:0]            state_q, state_d;
    logic [3:0]            type_q;
    logic [WIDTH-1:0]      addr_q;
    logic [BLOCK_SIZE-1:0] data_q;
    logic [BLOCK_SIZE-1:0] fill_q;
    logic                  excl_q;
    logic [CPU_WIDTH-1:0]  ack_num_q;
    logic                  inv_q;
    logic [WIDTH-1:0]      inv_addr_q;

    logic                  rx_hit, put_hit, data_hit, fwd;
    logic                  acks_met, tmo_hit, get_fill;
    logic [CPU_WIDTH-1:0]  rx_ack_eff, ack_target;

    assign rx_hit     = rx_en && (rx_addr == addr_q);
    assign fwd        = rx_type == FORWARD_DATA;
    assign put_hit    = rx_hit && rx_put_ack;
    assign data_hit   = rx_hit && ((rx_type == DATA) || fwd);
    assign rx_ack_eff = fwd ? '0 : rx_ack_num;
    assign get_fill   = (state_q == S_WAIT_RESP) && !is_put(type_q)
                        && data_hit;

    // In WAIT_RESP the ack target arrives with the data itself.
    assign ack_target = (state_q == S_WAIT_RESP) ? rx_ack_eff : ack_num_q;

    inv_ack_counter u_acks (
        .clk_i     (sys_clk),
        .rst_ni    (sys_rst_n),
        .clr_i     (state_q == S_IDLE),
        .inc_i     (last_ack_i != '0),
        .target_i  (ack_target),
        .reached_o (acks_met)
    );

`ifdef REQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             busy;

    assign busy = (state_q == S_ISSUE) || (state_q == S_WAIT_RESP)
                  || (state_q == S_WAIT_ACK);

    always_comb begin
        tmo_d = tmo_q;
        if (state_q == S_IDLE) begin
            tmo_d = '0;
        end else if (busy) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign tmo_hit = busy && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    assign timeout_err = tmo_hit;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (core_req_valid) state_d = S_ISSUE;
            S_ISSUE:     if (tx_grant_i) state_d = S_WAIT_RESP;
            S_WAIT_RESP: begin
                if (is_put(type_q)) begin
                    if (put_hit) state_d = S_DONE;
                end else if (data_hit) begin
                    state_d = acks_met ? S_DONE : S_WAIT_ACK;
                end
            end
            S_WAIT_ACK:  if (acks_met) state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
        if (tmo_hit) state_d = S_IDLE;
    end

    always_comb begin
        core_req_ready = 1'b0;
        tx_en          = 1'b0;
        tx_type        = NONE;
        tx_addr        = '0;
        tx_data        = '0;
        core_done      = 1'b0;
        core_done_data = '0;
        core_done_excl = 1'b0;
        unique case (1'b1)
            state_q == S_IDLE: core_req_ready = 1'b1;
            state_q == S_ISSUE: begin
                tx_en   = 1'b1;
                tx_type = type_q;
                tx_addr = addr_q;
                tx_data = data_q;
            end
            state_q == S_DONE: begin
                core_done      = 1'b1;
                core_done_data = fill_q;
                core_done_excl = excl_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            type_q     <= NONE;
            addr_q     <= '0;
            data_q     <= '0;
            fill_q     <= '0;
            excl_q     <= 1'b0;
            ack_num_q  <= '0;
            inv_q      <= 1'b0;
            inv_addr_q <= '0;
        end else begin
            if ((state_q == S_IDLE) && core_req_valid) begin
                type_q    <= core_req_type;
                addr_q    <= core_req_addr;
                data_q    <= core_req_data;
                // PUT completions report zero fill, so start clean.
                fill_q    <= '0;
                excl_q    <= 1'b0;
                ack_num_q <= '0;
            end
            if (get_fill) begin
                fill_q    <= rx_data;
                excl_q    <= !fwd && rx_exclusive;
                ack_num_q <= rx_ack_eff;
            end
            inv_q      <= inv_en_i;
            inv_addr_q <= inv_en_i ? inv_addr_i : '0;
        end
    end

    assign core_inv_en   = inv_q;
    assign inv_ack_o     = inv_q;
    assign core_inv_addr = inv_addr_q;

endmodule

// File: tb/tb_cache_req_agent.sv
// Self-checking bench for cache_req_agent: directed scenarios plus
// randomized transactions against an event-level completion model.
module tb_cache_req_agent;
    import cache_req_agent_pkg::*;

    logic                  sys_clk = 1'b0;
    logic                  sys_rst_n = 1'b0;
    logic                  core_req_valid = 1'b0;
    logic [3:0]            core_req_type = '0;
    logic [WIDTH-1:0]      core_req_addr = '0;
    logic [BLOCK_SIZE-1:0] core_req_data = '0;
    logic                  core_req_ready, core_done, core_done_excl;
    logic [BLOCK_SIZE-1:0] core_done_data;
    logic                  core_inv_en;
    logic [WIDTH-1:0]      core_inv_addr;
    logic                  tx_en;
    logic [3:0]            tx_type;
    logic [BLOCK_SIZE-1:0] tx_data;
    logic [WIDTH-1:0]      tx_addr;
    logic                  tx_grant_i = 1'b0;
    logic                  rx_en = 1'b0;
    logic [3:0]            rx_type = '0;
    logic [BLOCK_SIZE-1:0] rx_data = '0;
    logic [WIDTH-1:0]      rx_addr = '0;
    logic                  rx_exclusive = 1'b0;
    logic [CPU_WIDTH-1:0]  rx_ack_num = '0;
    logic                  rx_put_ack = 1'b0;
    logic [CPU_WIDTH-1:0]  last_ack_i = '0;
    logic                  inv_en_i = 1'b0;
    logic [WIDTH-1:0]      inv_addr_i = '0;
    logic                  inv_ack_o, timeout_err;

    int tests = 0;
    int fails = 0;

    cache_req_agent #(.TIMEOUT_CYCLES(16)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .core_req_valid(core_req_valid), .core_req_type(core_req_type),
        .core_req_addr(core_req_addr), .core_req_data(core_req_data),
        .core_req_ready(core_req_ready), .core_done(core_done),
        .core_done_data(core_done_data), .core_done_excl(core_done_excl),
        .core_inv_en(core_inv_en), .core_inv_addr(core_inv_addr),
        .tx_en(tx_en), .tx_type(tx_type), .tx_data(tx_data),
        .tx_addr(tx_addr), .tx_grant_i(tx_grant_i),
        .rx_en(rx_en), .rx_type(rx_type), .rx_data(rx_data),
        .rx_addr(rx_addr), .rx_exclusive(rx_exclusive),
        .rx_ack_num(rx_ack_num), .rx_put_ack(rx_put_ack),
        .last_ack_i(last_ack_i), .inv_en_i(inv_en_i),
        .inv_addr_i(inv_addr_i), .inv_ack_o(inv_ack_o),
        .timeout_err(timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive_rx(input logic [3:0] ty, input logic [31:0] a,
                            input logic [63:0] d, input logic ex,
                            input logic [1:0] an, input logic pa);
        rx_en = 1'b1; rx_type = ty; rx_addr = a; rx_data = d;
        rx_exclusive = ex; rx_ack_num = an; rx_put_ack = pa;
    endtask

    task automatic clear_rx;
        rx_en = 1'b0; rx_type = '0; rx_addr = '0; rx_data = '0;
        rx_exclusive = 1'b0; rx_ack_num = '0; rx_put_ack = 1'b0;
    endtask

    // Accept a request and grant it after g ISSUE cycles; returns in
    // the first WAIT_RESP cycle.
    task automatic run_issue(input logic [3:0] ty, input logic [31:0] a,
                             input logic [63:0] d, input int g);
        core_req_valid = 1'b1; core_req_type = ty;
        core_req_addr = a; core_req_data = d;
        tick;
        core_req_valid = 1'b0;
        repeat (g - 1) tick;
        tx_grant_i = 1'b1;
        tick;
        tx_grant_i = 1'b0;
    endtask

    task automatic test_reset;
        sys_rst_n = 1'b0;
        tick; tick;
        tests++;
        if ({core_req_ready, tx_en, core_done, core_inv_en, inv_ack_o,
             timeout_err, core_done_excl} !== 7'b1000000) begin
            fails++;
            $display("FAIL reset_ctl: got %b want 1000000",
                {core_req_ready, tx_en, core_done, core_inv_en, inv_ack_o,
                 timeout_err, core_done_excl});
        end
        tests++;
        if ({tx_type, tx_addr, tx_data, core_done_data, core_inv_addr}
            !== '0) begin
            fails++;
            $display("FAIL reset_data: got %h %h %h want 0",
                tx_type, tx_addr, tx_data);
        end
        sys_rst_n = 1'b1;
        tick;
    endtask

    task automatic test_get_s;
        logic [63:0] fd;
        fd = 64'hDEAD_BEEF_0123_4567;
        core_req_valid = 1'b1; core_req_type = GET_S;
        core_req_addr = 32'h40; core_req_data = '0;
        tests++;
        if (core_req_ready !== 1'b1) begin
            fails++; $display("FAIL gets_ready: got %b want 1", core_req_ready);
        end
        tick;
        core_req_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            tests++;
            if ({tx_en, tx_type, tx_addr} !== {1'b1, GET_S, 32'h40}) begin
                fails++;
                $display("FAIL gets_tx c%0d: got %b %h %h want 1 1 40",
                    c, tx_en, tx_type, tx_addr);
            end
            if (c == 3) tx_grant_i = 1'b1;
            tick;
        end
        tx_grant_i = 1'b0;
        tests++;
        if ({tx_en, core_req_ready} !== 2'b00) begin
            fails++; $display("FAIL gets_txdrop: got %b want 00",
                {tx_en, core_req_ready});
        end
        drive_rx(DATA, 32'h40, fd, 1'b0, 2'd0, 1'b0);
        tick;
        clear_rx;
        tests++;
        if ({core_done, core_done_excl, core_done_data} !== {1'b1, 1'b0, fd})
        begin
            fails++; $display("FAIL gets_done: got %b %b %h want 1 0 %h",
                core_done, core_done_excl, core_done_data, fd);
        end
        tick;
        tests++;
        if ({core_done, core_req_ready} !== 2'b01) begin
            fails++; $display("FAIL gets_idle: got %b want 01",
                {core_done, core_req_ready});
        end
    endtask

    task automatic test_getm_ack_after;
        logic [63:0] fd;
        fd = 64'h1111_2222_3333_4444;
        run_issue(GET_M, 32'h80, '0, 1);
        drive_rx(DATA, 32'h80, fd, 1'b1, 2'd1, 1'b0);
        tick;
        clear_rx;
        tests++;
        if ({core_done, core_req_ready} !== 2'b00) begin
            fails++; $display("FAIL getm_wait: got %b want 00",
                {core_done, core_req_ready});
        end
        last_ack_i = 2'd1;
        tick;
        last_ack_i = '0;
        tests++;
        if ({core_done, core_done_excl, core_done_data} !== {1'b1, 1'b1, fd})
        begin
            fails++; $display("FAIL getm_done: got %b %b %h want 1 1 %h",
                core_done, core_done_excl, core_done_data, fd);
        end
        tick;
    endtask

    task automatic test_ack_before_data;
        logic [63:0] fd;
        fd = 64'h5555_6666_7777_8888;
        run_issue(GET_M, 32'hC0, '0, 2);
        last_ack_i = 2'd2;
        tick;
        last_ack_i = '0;
        drive_rx(DATA, 32'hC0, fd, 1'b1, 2'd1, 1'b0);
        tick;
        clear_rx;
        tests++;
        if ({core_done, core_done_excl, core_done_data} !== {1'b1, 1'b1, fd})
        begin
            fails++; $display("FAIL early_ack: got %b %b %h want 1 1 %h",
                core_done, core_done_excl, core_done_data, fd);
        end
        tick;
    endtask

    task automatic test_put_m;
        logic [63:0] wd;
        wd = {8{8'hA5}};
        core_req_valid = 1'b1; core_req_type = PUT_M;
        core_req_addr = 32'h100; core_req_data = wd;
        tick;
        core_req_valid = 1'b0;
        tests++;
        if ({tx_en, tx_type, tx_data} !== {1'b1, PUT_M, wd}) begin
            fails++; $display("FAIL put_tx: got %b %h %h want 1 5 %h",
                tx_en, tx_type, tx_data, wd);
        end
        tx_grant_i = 1'b1;
        tick;
        tx_grant_i = 1'b0;
        drive_rx(DATA, 32'h104, '1, 1'b1, 2'd0, 1'b1);
        tick;
        clear_rx;
        tests++;
        if (core_done !== 1'b0) begin
            fails++; $display("FAIL put_badaddr: got %b want 0", core_done);
        end
        drive_rx(NONE, 32'h100, '1, 1'b1, 2'd0, 1'b1);
        tick;
        clear_rx;
        tests++;
        if ({core_done, core_done_excl, core_done_data} !== {2'b10, 64'h0})
        begin
            fails++; $display("FAIL put_done: got %b %b %h want 1 0 0",
                core_done, core_done_excl, core_done_data);
        end
        tick;
    endtask

    task automatic test_inv_b2b;
        run_issue(GET_S, 32'h200, '0, 1);
        inv_en_i = 1'b1; inv_addr_i = 32'hAAAA_0000;
        tick;
        tests++;
        if ({core_inv_en, inv_ack_o, core_inv_addr} !==
            {2'b11, 32'hAAAA_0000}) begin
            fails++; $display("FAIL inv_first: got %b %b %h want 1 1 aaaa0000",
                core_inv_en, inv_ack_o, core_inv_addr);
        end
        inv_addr_i = 32'hBBBB_0040;
        tick;
        inv_en_i = 1'b0; inv_addr_i = '0;
        tests++;
        if ({core_inv_en, inv_ack_o, core_inv_addr} !==
            {2'b11, 32'hBBBB_0040}) begin
            fails++; $display("FAIL inv_second: got %b %b %h want 1 1 bbbb0040",
                core_inv_en, inv_ack_o, core_inv_addr);
        end
        tick;
        tests++;
        if ({inv_ack_o, core_inv_en, core_done, core_req_ready} !== 4'b0000)
        begin
            fails++; $display("FAIL inv_quiet: got %b want 0000",
                {inv_ack_o, core_inv_en, core_done, core_req_ready});
        end
        drive_rx(DATA, 32'h200, 64'h42, 1'b0, 2'd0, 1'b0);
        tick;
        clear_rx;
        tests++;
        if ({core_done, core_done_data} !== {1'b1, 64'h42}) begin
            fails++; $display("FAIL inv_fsm: got %b %h want 1 42",
                core_done, core_done_data);
        end
        tick;
    endtask

    task automatic test_reset_midflight;
        bit seen;
        run_issue(GET_M, 32'h280, '0, 1);
        drive_rx(DATA, 32'h280, 64'h99, 1'b1, 2'd2, 1'b0);
        tick;
        clear_rx;
        inv_en_i = 1'b1; inv_addr_i = 32'h1234;
        sys_rst_n = 1'b0;
        tick;
        inv_en_i = 1'b0; inv_addr_i = '0;
        sys_rst_n = 1'b1;
        tests++;
        if ({core_req_ready, tx_en, core_done, core_inv_en, inv_ack_o,
             timeout_err, core_done_excl, core_done_data, core_inv_addr,
             tx_type} !== {1'b1, 6'b0, 64'h0, 32'h0, NONE}) begin
            fails++; $display("FAIL rst_flight: got %b %h %h want 1 0 0",
                {core_req_ready, tx_en, core_done, core_inv_en, inv_ack_o},
                core_done_data, core_inv_addr);
        end
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            last_ack_i = (c < 2) ? 2'd1 : 2'd0;
            tick;
            if (core_done === 1'b1) seen = 1'b1;
        end
        last_ack_i = '0;
        tests++;
        if ({seen, core_req_ready} !== 2'b01) begin
            fails++; $display("FAIL rst_drop: got %b want 01",
                {seen, core_req_ready});
        end
    endtask

    task automatic test_timeout;
        bit tmo;
`ifdef REQ_TIMEOUT_EN
        tmo = 1'b1;
`else
        tmo = 1'b0;
`endif
        core_req_valid = 1'b1; core_req_type = GET_S;
        core_req_addr = 32'h300; core_req_data = '0;
        tick;
        core_req_valid = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            tests++;
            if (timeout_err !== (tmo && (c == 16))) begin
                fails++; $display("FAIL tmo_c%0d: got %b want %b",
                    c, timeout_err, tmo && (c == 16));
            end
            tick;
        end
        tests++;
        if ({core_req_ready, core_done, timeout_err} !== {tmo, 2'b00}) begin
            fails++; $display("FAIL tmo_after: got %b want %b00",
                {core_req_ready, core_done, timeout_err}, tmo);
        end
        if (!tmo) begin
            tx_grant_i = 1'b1;
            tick;
            tx_grant_i = 1'b0;
            drive_rx(DATA, 32'h300, 64'h7, 1'b0, 2'd0, 1'b0);
            tick;
            clear_rx;
            tick;
        end
        tests++;
        if (core_req_ready !== 1'b1) begin
            fails++; $display("FAIL tmo_idle: got %b want 1", core_req_ready);
        end
    endtask

    // Completion model: a GET finishes the cycle after both its data and
    // its required number of acks have been seen; a PUT the cycle after
    // its put-ack. Mismatched-address responses must be ignored.
    task automatic test_random;
        logic        put, fwd, excl, fin, exp_ex;
        logic [3:0]  ty;
        logic [31:0] a;
        logic [63:0] wd, rd, exp_d;
        int g, d, bad, n, need, given, nth, e;
        for (int t = 0; t < 40; t++) begin
            put  = ($urandom_range(0, 3) == 0);
            fwd  = ($urandom_range(0, 2) == 0);
            excl = 1'($urandom_range(0, 1));
            ty   = put ? 4'(PUT_S + 4'($urandom_range(0, 2)))
                       : ($urandom_range(0, 1) == 1 ? GET_M : GET_S);
            a    = $urandom & 32'hFFFF_FFF0;
            wd   = {$urandom, $urandom};
            rd   = {$urandom, $urandom};
            g    = $urandom_range(1, 4);
            d    = $urandom_range(0, 4);
            bad  = $urandom_range(0, 5);
            n    = $urandom_range(0, 3);
            need = (put || fwd) ? 0 : n;
            given = 0; nth = -1; fin = 1'b0;
            exp_d  = put ? 64'h0 : rd;
            exp_ex = !put && !fwd && excl;
            core_req_valid = 1'b1; core_req_type = ty;
            core_req_addr = a; core_req_data = wd;
            tests++;
            if (core_req_ready !== 1'b1) begin
                fails++; $display("FAIL rnd%0d_ready: got %b want 1",
                    t, core_req_ready);
            end
            tick;
            core_req_valid = 1'b0;
            for (int k = 1; k <= g; k++) begin
                tests++;
                if ({tx_en, tx_type, tx_addr, tx_data} !== {1'b1, ty, a, wd})
                begin
                    fails++; $display("FAIL rnd%0d_tx: got %b %h %h %h want 1 %h %h %h",
                        t, tx_en, tx_type, tx_addr, tx_data, ty, a, wd);
                end
                if (k == g) tx_grant_i = 1'b1;
                tick;
            end
            tx_grant_i = 1'b0;
            for (int c = 0; c <= 20 && !fin; c++) begin
                e = -1;
                if (d < c && (need == 0 || nth >= 0))
                    e = ((need == 0 || d > nth) ? d : nth) + 1;
                tests++;
                if (core_done !== (c == e)) begin
                    fails++; $display("FAIL rnd%0d_done c%0d: got %b want %b",
                        t, c, core_done, c == e);
                end
                if (c == e) begin
                    fin = 1'b1;
                    tests++;
                    if ({core_done_data, core_done_excl} !== {exp_d, exp_ex})
                    begin
                        fails++; $display("FAIL rnd%0d_fill: got %h %b want %h %b",
                            t, core_done_data, core_done_excl, exp_d, exp_ex);
                    end
                end
                clear_rx;
                last_ack_i = '0;
                if (!fin) begin
                    if (c == d)
                        drive_rx(put ? NONE : (fwd ? FORWARD_DATA : DATA),
                                 a, rd, excl, 2'(n), put);
                    else if (c == bad)
                        drive_rx(DATA, a ^ 32'h4, ~rd, 1'b1, 2'd0, 1'b1);
                    if (!put && given < n &&
                        ($urandom_range(0, 1) == 1 || c >= 5)) begin
                        last_ack_i = 2'($urandom_range(1, 3));
                        given++;
                        if (given == n) nth = c;
                    end
                    tick;
                end
            end
            if (!fin) begin
                tests++; fails++;
                $display("FAIL rnd%0d_bound: got no completion want done", t);
                sys_rst_n = 1'b0; tick; sys_rst_n = 1'b1;
            end
            clear_rx;
            last_ack_i = '0;
            tick;
            tests++;
            if ({core_req_ready, core_done} !== 2'b10) begin
                fails++; $display("FAIL rnd%0d_idle: got %b want 10",
                    t, {core_req_ready, core_done});
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got hang want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_get_s;
        test_getm_ack_after;
        test_ack_before_data;
        test_put_m;
        test_inv_b2b;
        test_reset_midflight;
        test_timeout;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cache_req_agent.md
CACHE_REQ_AGENT -- requirements
Module: cache_req_agent

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 1024, which sets the watchdog limit in cycles (used only under REQ_TIMEOUT_EN).
REQ-002 The module SHALL use one clock and a synchronous, active-low reset, with ports as listed below.
- sys_clk  in  1  clock.
- sys_rst_n  in  1  synchronous active-low reset.
- core_req_valid  in  1  core request.
- core_req_type  in  4  GET_S/GET_M/PUT_S/PUT_E/PUT_M.
- core_req_addr  in  WIDTH  block address.
- core_req_data  in  BLOCK_SIZE  writeback data for PUT_E/PUT_M.
- core_req_ready  out  1  agent idle; request accepted when valid&ready.
- core_done  out  1  one-cycle completion pulse.
- core_done_data  out  BLOCK_SIZE  fill data.
- core_done_excl  out  1  fill granted exclusive.
- core_inv_en  out  1  invalidate pulse to cache array.
- core_inv_addr  out  WIDTH  address to invalidate.
- tx_en  out  1  request to crossbar.
- tx_type  out  4  request type.
- tx_data  out  BLOCK_SIZE  request data.
- tx_addr  out  WIDTH  request address.
- tx_grant_i  in  1  crossbar accepted tx this cycle.
- rx_en  in  1  response valid.
- rx_type  in  4  DATA or FORWARD_DATA.
- rx_data  in  BLOCK_SIZE  response data.
- rx_addr  in  WIDTH  response address.
- rx_exclusive  in  1  exclusive grant.
- rx_ack_num  in  CPU_WIDTH  invalidation acks to collect.
- rx_put_ack  in  1  put acknowledged.
- last_ack_i  in  CPU_WIDTH  invalidation ack pulse from a peer (nonzero = one ack).
- inv_en_i  in  1  invalidation from directory.
- inv_addr_i  in  WIDTH  invalidation address.
- inv_ack_o  out  1  ack back to crossbar.
- timeout_err  out  1  watchdog pulse.

Function
REQ-003 The FSM SHALL have the states IDLE, ISSUE, WAIT_RESP, WAIT_ACK, and DONE; core_req_ready SHALL equal (state==IDLE).
REQ-004 On IDLE&core_req_valid, the module SHALL latch the type, address and data and go to ISSUE.
REQ-005 In ISSUE, tx_en SHALL be held high with stable fields until tx_grant_i is sampled high; in the following cycle tx_en SHALL be 0 and the state SHALL be WAIT_RESP.
REQ-006 In WAIT_RESP, if the latched type is PUT_*, the module SHALL go to DONE when rx_en&rx_put_ack are sampled high.
REQ-007 In WAIT_RESP, if the latched type is GET_*, rx_en with type DATA or FORWARD_DATA SHALL capture the data, rx_exclusive and rx_ack_num.
- FORWARD_DATA forces exclusive=0 and ack_num=0.
- Transition: to DONE if acks_rcvd>=ack_num, otherwise to WAIT_ACK.
REQ-008 acks_rcvd (CPU_WIDTH+1 bits, saturating) SHALL increment on every cycle with last_ack_i!=0 while state is not IDLE, including acks that arrive before the data; it SHALL clear on entry to IDLE.
REQ-009 WAIT_ACK SHALL go to DONE in the cycle after acks_rcvd reaches ack_num.
- This includes the case of an ack and data arriving in the same cycle.
REQ-010 DONE SHALL pulse core_done for one cycle with core_done_data and core_done_excl valid, then return to IDLE.
- For PUT_* requests, core_done_data=0 and core_done_excl=0.
REQ-011 The module SHALL ignore rx_en whose rx_addr does not match the latched address, and any rx_en received in IDLE.
REQ-012 On inv_en_i, exactly one cycle later core_inv_en=1, core_inv_addr=inv_addr_i and inv_ack_o=1, all for one cycle.
- This happens in every state and is independent of the FSM.
- Back-to-back invalidations SHALL each produce one ack.

Reset
REQ-013 With sys_rst_n=0 at a clock edge, the module SHALL set the state to IDLE and set every output and internal register to 0.
- tx_type SHALL reset to NONE.
- A transaction in flight at reset SHALL be dropped without producing core_done.

Configuration
REQ-014 With REQ_TIMEOUT_EN defined, a counter SHALL count cycles spent in ISSUE, WAIT_RESP and WAIT_ACK.
- On reaching TIMEOUT_CYCLES, timeout_err SHALL pulse for one cycle and the state SHALL go to IDLE without core_done.
- The counter clears on entry to IDLE.
REQ-015 Without REQ_TIMEOUT_EN, no counter SHALL exist and timeout_err SHALL be tied to 0.

Structure
REQ-016 Transaction type encodings (NONE, GET_S, GET_M, PUT_*, DATA, FORWARD_DATA) and WIDTH, BLOCK_SIZE and CPU_WIDTH SHALL come from the shared define.v; the FSM state encodings SHALL be local parameters.
REQ-017 Ack accounting (saturating counter plus the compare against ack_num) SHALL be the sub-module inv_ack_counter.

Verification
REQ-018 The bench SHALL cover the following directed scenarios.
- GET_S at 0x40, grant at cycle 3, DATA with ack_num=0 -> tx_en high for cycles 1-3, then core_done with data and excl=0.
- GET_M, DATA ack_num=1 then last_ack_i one cycle later -> core_done one cycle after the ack, excl=1.
- GET_M, last_ack_i arrives before DATA with ack_num=1 -> core_done the cycle after DATA, with no WAIT_ACK dwell.
- PUT_M, data 0xA5.., then rx_put_ack -> tx_data=0xA5.., core_done with data=0.
- inv_en_i on two consecutive cycles during WAIT_RESP -> two inv_ack_o pulses, each one cycle later, with the FSM unaffected.
- sys_rst_n low during WAIT_ACK -> all outputs 0 next edge; with REQ_TIMEOUT_EN and TIMEOUT_CYCLES=16 and no response, timeout_err pulses at cycle 16.
